// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gated edge-count frequency meter with divider phase alignment.
// Define FREQ_GATE_CONT_EN for continuous back-to-back windows; otherwise each measurement is single-shot.
module freq_gate_ctrl #(
  parameter int          CNT_W       = 27,
  parameter int unsigned ARM_TIMEOUT = 27'd100_000_000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_1hz,
  input  logic             sig_in,
  output logic             div_clr,
  output logic             gate,
  output logic             busy,
  output logic [CNT_W-1:0] freq_val,
  output logic             freq_vld,
  output logic             ovf,
  output logic             tmo
);
  typedef enum logic [2:0] {IDLE, SYNC, ARM, GATE, LATCH} state_t;
  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, freq_val_q, freq_val_d;
  logic [31:0]      tcnt_q, tcnt_d;
  logic             win_ovf_q, win_ovf_d, freq_vld_q, freq_vld_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic             div_clr_q, div_clr_d, gate_q, gate_d, busy_q, busy_d;
  logic             edge_p;
  assign edge_p = sync_q[1] & ~sync_q[2];
  always_comb begin
    sync_d     = {sync_q[1:0], sig_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    win_ovf_d  = win_ovf_q;
    freq_val_d = freq_val_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = SYNC;
        tmo_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      SYNC: begin
        cnt_d     = '0;
        tcnt_d    = '0;
        win_ovf_d = 1'b0;
        state_d   = stop ? IDLE : ARM;
      end
      ARM: begin
        if (stop) state_d = IDLE;
        else if (tick_1hz) state_d = GATE;
        else if (tcnt_q == ARM_TIMEOUT - 1) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else tcnt_d = tcnt_q + 1;
      end
      GATE: begin
        if (stop) begin
          state_d   = IDLE;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
        end else begin
          // saturate rather than wrap; an edge arriving at all-ones marks the window as overflowed
          if (edge_p) begin
            cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            win_ovf_d = win_ovf_q | (&cnt_q);
          end
          if (tick_1hz) begin
            state_d    = LATCH;
            freq_val_d = cnt_d;
            ovf_d      = win_ovf_d;
          end
        end
      end
      LATCH: begin
        win_ovf_d = 1'b0;
`ifdef FREQ_GATE_CONT_EN
        // an edge landing in this cycle belongs to the window that is already reopening
        state_d = stop ? IDLE : GATE;
        cnt_d   = stop ? '0 : {{(CNT_W-1){1'b0}}, edge_p};
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
    freq_vld_d = state_d == LATCH;
    gate_d     = state_d == GATE;
    busy_d     = state_d != IDLE;
    div_clr_d  = state_d == SYNC;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      win_ovf_q  <= 1'b0;
      freq_val_q <= '0;
      freq_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      div_clr_q  <= 1'b0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      win_ovf_q  <= win_ovf_d;
      freq_val_q <= freq_val_d;
      freq_vld_q <= freq_vld_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      div_clr_q  <= div_clr_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
    end
  end
  assign div_clr  = div_clr_q;
  assign gate     = gate_q;
  assign busy     = busy_q;
  assign freq_val = freq_val_q;
  assign freq_vld = freq_vld_q;
  assign ovf      = ovf_q;
  assign tmo      = tmo_q;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: two instances (27-bit and 8-bit counters) share one stimulus stream and
// are checked every cycle against an unbounded-count behavioural model, plus directed literal checks.
module tb_freq_gate_ctrl;
  localparam int T  = 1000;
  localparam int M0 = (1 << 27) - 1;
  localparam int M1 = 255;
  logic clk = 0, clr_n, start, stop, tick, sig_in;
  logic div_clr0, gate0, busy0, vld0, ovf0, tmo0;
  logic div_clr1, gate1, busy1, vld1, ovf1, tmo1;
  logic [26:0] val0;
  logic [7:0]  val1;
  int errs = 0, checks = 0, nvld = 0, v, n;
  int ph, cnt, tc, lat0, lat1;
  bit ov0, ov1, etmo, mp;
  bit [2:0] hist;
  always #5 clk = ~clk;
  freq_gate_ctrl #(.ARM_TIMEOUT(T)) u0 (.clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .tick_1hz(tick), .sig_in(sig_in), .div_clr(div_clr0), .gate(gate0), .busy(busy0),
    .freq_val(val0), .freq_vld(vld0), .ovf(ovf0), .tmo(tmo0));
  freq_gate_ctrl #(.CNT_W(8), .ARM_TIMEOUT(T)) u1 (.clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .tick_1hz(tick), .sig_in(sig_in), .div_clr(div_clr1), .gate(gate1), .busy(busy1),
    .freq_val(val1), .freq_vld(vld1), .ovf(ovf1), .tmo(tmo1));
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // phases: 0 idle, 1 sync, 2 arm, 3 gate, 4 latch; counts are unbounded and clamped only when latched
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ph = 0; cnt = 0; tc = 0; hist = '0; lat0 = 0; lat1 = 0; ov0 = 0; ov1 = 0; etmo = 0;
    end else begin
      mp = hist[1] && !hist[2];
      hist = {hist[1:0], sig_in};
      case (ph)
        0: if (start && !stop) begin ph = 1; etmo = 0; ov0 = 0; ov1 = 0; end
        1: begin cnt = 0; tc = 0; ph = stop ? 0 : 2; end
        2: if (stop) ph = 0;
           else if (tick) ph = 3;
           else if (tc == T - 1) begin ph = 0; etmo = 1; end
           else tc++;
        3: if (stop) begin ph = 0; cnt = 0; end
           else begin
             cnt += int'(mp);
             if (tick) begin
               ph = 4;
               lat0 = cnt > M0 ? M0 : cnt; ov0 = cnt > M0;
               lat1 = cnt > M1 ? M1 : cnt; ov1 = cnt > M1;
             end
           end
        default: begin
`ifdef FREQ_GATE_CONT_EN
          ph = stop ? 0 : 3; cnt = stop ? 0 : int'(mp);
`else
          ph = 0; cnt = 0;
`endif
        end
      endcase
    end
  end
  always @(negedge clk) begin
    chk("busy0", busy0, ph != 0);       chk("busy1", busy1, ph != 0);
    chk("gate0", gate0, ph == 3);       chk("gate1", gate1, ph == 3);
    chk("div_clr0", div_clr0, ph == 1); chk("div_clr1", div_clr1, ph == 1);
    chk("vld0", vld0, ph == 4);         chk("vld1", vld1, ph == 4);
    chk("val0", val0, lat0);            chk("val1", val1, lat1);
    chk("ovf0", ovf0, ov0);             chk("ovf1", ovf1, ov1);
    chk("tmo0", tmo0, etmo);            chk("tmo1", tmo1, etmo);
  end
  always @(posedge clk) if (vld0) nvld++;
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic drive(input logic s, input logic p, input logic t);
    start = s; stop = p; tick = t;
    @(negedge clk);
    start = 0; stop = 0; tick = 0;
  endtask
  task automatic edges(input int k, input int sp);
    repeat (k) begin
      sig_in = 1; cyc(2);
      sig_in = 0; cyc(sp - 2);
    end
  endtask
  task automatic open_gate();
    drive(1, 0, 0); cyc(2); drive(0, 0, 1);
  endtask
  task automatic close_gate();
    cyc(3); drive(0, 0, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    clr_n = 0; start = 0; stop = 0; tick = 0; sig_in = 0;
    cyc(3);
    chk("rst_busy", busy0, 0); chk("rst_val", val0, 0); chk("rst_tmo", tmo1, 0);
    clr_n = 1;
    drive(1, 0, 0);
    chk("first_start_div_clr", div_clr0, 1);
    cyc(1); drive(0, 0, 1);
    chk("gate_open", gate0, 1);
    edges(1000, 7); close_gate();
    chk("a_vld", vld0, 1); chk("a_val0", val0, 1000); chk("a_ovf0", ovf0, 0);
    chk("a_val1", val1, 255); chk("a_ovf1", ovf1, 1);
    drive(0, 1, 0); cyc(2);
    chk("a_idle", busy0, 0); chk("a_nvld", nvld, 1);
    open_gate();
    chk("b_ovf_cleared", ovf1, 0);
    edges(300, 4); close_gate();
    chk("b_val1", val1, 255); chk("b_ovf1", ovf1, 1); chk("b_val0", val0, 300);
    drive(0, 1, 0);
    open_gate(); edges(10, 5); close_gate();
    chk("c_val1", val1, 10); chk("c_ovf1", ovf1, 0);
    drive(0, 1, 0);
    drive(0, 0, 1); cyc(1); chk("idle_tick", busy0, 0);
    drive(1, 1, 0); cyc(1); chk("start_stop", busy0, 0);
    v = nvld;
    drive(1, 0, 0);
    n = 0;
    while (busy0 && n < 3000) begin n++; cyc(1); end
    chk("tmo_cycles", n, 1001); chk("tmo_flag", tmo0, 1); chk("tmo_novld", nvld, v);
    drive(1, 0, 0); chk("tmo_clear", tmo0, 0);
    drive(0, 1, 0); chk("sync_stop", busy0, 0);
    open_gate(); edges(50, 10); drive(0, 1, 0);
    chk("stop_idle", busy0, 0); cyc(3);
    chk("stop_val", val0, 10); chk("stop_novld", nvld, v);
    open_gate(); edges(20, 5); cyc(3); drive(0, 1, 1); cyc(3);
    chk("stoptick_val", val0, 10); chk("stoptick_novld", nvld, v); chk("stoptick_idle", busy0, 0);
    open_gate(); edges(4, 6);
    sig_in = 1; cyc(2); drive(0, 0, 1); sig_in = 0;
    chk("coinc_val", val0, 5);
    drive(0, 1, 0); cyc(2);
    v = nvld;
    open_gate(); edges(10, 5);
    #2 clr_n = 0;
    #1;
    chk("r_busy", busy0, 0); chk("r_gate", gate0, 0); chk("r_val0", val0, 0); chk("r_val1", val1, 0);
    chk("r_vld", vld0, 0); chk("r_div", div_clr0, 0); chk("r_ovf", ovf0, 0); chk("r_tmo", tmo0, 0);
    @(negedge clk); clr_n = 1;
    chk("r_novld", nvld, v);
    open_gate(); edges(8, 5); close_gate();
    chk("fresh_val", val0, 8); chk("fresh_vld", vld0, 1);
    drive(0, 1, 0);
`ifdef FREQ_GATE_CONT_EN
    open_gate(); edges(5, 5); close_gate();
    chk("cont_w1", val0, 5);
    edges(6, 5); close_gate();
    chk("cont_w2", val0, 6);
    edges(7, 5); close_gate();
    chk("cont_w3", val0, 7);
    drive(0, 1, 0);
`endif
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
